// File: rtl/rtype_regfile_wb_if.sv
// Instruction/operand/writeback bundle between the issue side and the R-type register file.
// Handshake: an instruction transfers on a rising clk edge where instr_valid and instr_ready are both 1.
interface rtype_regfile_wb_if #(parameter int N = 32);
   logic          instr_valid;
   logic          instr_ready;
   logic [31:0]   instruction_R;
   logic [N-1:0]  Read_data1_R;
   logic [N-1:0]  Read_data2_R;
   logic          op_valid;
   logic [N-1:0]  ALUResult_R;
   logic          wb_en;
   logic [4:0]    wb_addr;
   logic [N-1:0]  wb_data;
   logic          illegal;

   modport master (
      output instr_valid, instruction_R, ALUResult_R,
      input  instr_ready, Read_data1_R, Read_data2_R, op_valid,
             wb_en, wb_addr, wb_data, illegal
   );

   modport slave (
      input  instr_valid, instruction_R, ALUResult_R,
      output instr_ready, Read_data1_R, Read_data2_R, op_valid,
             wb_en, wb_addr, wb_data, illegal
   );
endinterface

// File: rtl/rtype_regfile_wb.sv
// R-type register file: accepts an instruction, issues its operands one cycle later, writes the ALU result back.
// Define WB_BYPASS_EN to forward ALUResult_R on a read-after-write hazard instead of stalling one cycle.
module rtype_regfile_wb #(
   parameter int N = 32
) (
   input  logic              clk,
   input  logic              rst,
   rtype_regfile_wb_if.slave bus
);
   localparam logic [6:0] OP_RTYPE = 7'b0110011;

   logic [N-1:0] regs_q [32];
   logic [N-1:0] rd1_q, rd1_d;
   logic [N-1:0] rd2_q, rd2_d;
   logic         op_valid_q, op_valid_d;
   logic         illegal_q, illegal_d;
   logic [4:0]   rd_q, rd_d;

   logic [4:0]   rs1, rs2, rd;
   logic [6:0]   opcode;
   logic         legal, pend_wr, hazard, ready, accept;
   logic [N-1:0] opnd1, opnd2;
   logic         unused_bits;

   assign rs1         = bus.instruction_R[19:15];
   assign rs2         = bus.instruction_R[24:20];
   assign rd          = bus.instruction_R[11:7];
   assign opcode      = bus.instruction_R[6:0];
   assign unused_bits = ^{bus.instruction_R[31:25], bus.instruction_R[14:12]};
   assign legal       = (opcode == OP_RTYPE);

   // A pending write to a non-zero rd lands at the closing edge of the issue cycle.
   assign pend_wr = op_valid_q && (rd_q != 5'd0);
   assign hazard  = bus.instr_valid && pend_wr && ((rs1 == rd_q) || (rs2 == rd_q));

`ifdef WB_BYPASS_EN
   assign ready = !rst;
`else
   assign ready = !rst && !hazard;
`endif
   assign accept = bus.instr_valid && ready;

   always_comb begin
      opnd1 = (rs1 == 5'd0) ? '0 : regs_q[rs1];
      opnd2 = (rs2 == 5'd0) ? '0 : regs_q[rs2];
`ifdef WB_BYPASS_EN
      if (hazard && (rs1 == rd_q)) opnd1 = bus.ALUResult_R;
      if (hazard && (rs2 == rd_q)) opnd2 = bus.ALUResult_R;
`endif
   end

   always_comb begin
      rd1_d      = rd1_q;
      rd2_d      = rd2_q;
      rd_d       = rd_q;
      op_valid_d = 1'b0;
      illegal_d  = 1'b0;
      if (accept) begin
         rd_d       = rd;
         op_valid_d = legal;
         illegal_d  = !legal;
         if (legal) begin
            rd1_d = opnd1;
            rd2_d = opnd2;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) regs_q[i] <= '0;
         rd1_q      <= '0;
         rd2_q      <= '0;
         rd_q       <= '0;
         op_valid_q <= 1'b0;
         illegal_q  <= 1'b0;
      end else begin
         if (pend_wr) regs_q[rd_q] <= bus.ALUResult_R;
         rd1_q      <= rd1_d;
         rd2_q      <= rd2_d;
         rd_q       <= rd_d;
         op_valid_q <= op_valid_d;
         illegal_q  <= illegal_d;
      end
   end

   assign bus.instr_ready  = ready;
   assign bus.Read_data1_R = rd1_q;
   assign bus.Read_data2_R = rd2_q;
   assign bus.op_valid     = op_valid_q;
   assign bus.illegal      = illegal_q;
   assign bus.wb_en        = pend_wr;
   assign bus.wb_addr      = op_valid_q ? rd_q : 5'd0;
   assign bus.wb_data      = op_valid_q ? bus.ALUResult_R : '0;
endmodule

// File: tb/tb_rtype_regfile_wb.sv
// Bench for rtype_regfile_wb: directed scenarios then random traffic against an architectural register model.
// Honours WB_BYPASS_EN the same way as the design.
module tb_rtype_regfile_wb;
   localparam int N = 32;
   localparam logic [6:0] OP_R = 7'b0110011;
   localparam logic [6:0] OP_I = 7'b0010011;
`ifdef WB_BYPASS_EN
   localparam int EXP_STALL = 0;
`else
   localparam int EXP_STALL = 1;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rtype_regfile_wb_if #(.N(N)) bus ();
   rtype_regfile_wb #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_vec = 0;
   int n_err = 0;

   // Architectural model: register values plus what the issue stage should show next cycle.
   logic [N-1:0] model [32];
   logic         pend_v, exp_ill;
   logic [4:0]   pend_rd;
   logic [N-1:0] exp_rd1, exp_rd2;
   logic         obs_ready;

   function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
      return {7'b0, rs2, rs1, 3'b0, rd, op};
   endfunction

   task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic reset_model();
      for (int i = 0; i < 32; i++) model[i] = '0;
      pend_v  = 1'b0;
      pend_rd = 5'd0;
      exp_ill = 1'b0;
      exp_rd1 = '0;
      exp_rd2 = '0;
   endtask

   // One clock cycle: drive at negedge, check everything, then advance the model across the edge.
   task automatic cycle(input logic v, input logic [31:0] ins, input logic [N-1:0] alu,
                        output logic acc);
      logic hz, exp_rdy, lg;
      @(negedge clk);
      bus.instr_valid   = v;
      bus.instruction_R = ins;
      bus.ALUResult_R   = alu;
      #1;
      hz = v && pend_v && (pend_rd != 5'd0) &&
           ((ins[19:15] == pend_rd) || (ins[24:20] == pend_rd));
      exp_rdy = (EXP_STALL == 0) ? 1'b1 : !hz;
      obs_ready = bus.instr_ready;
      chk("instr_ready", {31'b0, bus.instr_ready}, {31'b0, exp_rdy});
      chk("op_valid", {31'b0, bus.op_valid}, {31'b0, pend_v});
      chk("illegal", {31'b0, bus.illegal}, {31'b0, exp_ill});
      chk("read_data1", bus.Read_data1_R, exp_rd1);
      chk("read_data2", bus.Read_data2_R, exp_rd2);
      chk("wb_en", {31'b0, bus.wb_en}, {31'b0, pend_v && (pend_rd != 5'd0)});
      if (pend_v) begin
         chk("wb_addr", {27'b0, bus.wb_addr}, {27'b0, pend_rd});
         chk("wb_data", bus.wb_data, alu);
      end
      acc = v && exp_rdy;
      @(posedge clk);
      if (pend_v && (pend_rd != 5'd0)) model[pend_rd] = alu;
      if (acc) begin
         lg      = (ins[6:0] == OP_R);
         pend_v  = lg;
         exp_ill = !lg;
         pend_rd = ins[11:7];
         if (lg) begin
            exp_rd1 = model[ins[19:15]];
            exp_rd2 = model[ins[24:20]];
         end
      end else begin
         pend_v  = 1'b0;
         exp_ill = 1'b0;
      end
   endtask

   // Present an instruction until it is accepted; stalls counts cycles the DUT showed instr_ready=0.
   task automatic issue(input logic [31:0] ins, input logic [N-1:0] alu, output int stalls);
      logic acc;
      int   tries;
      stalls = 0;
      tries  = 0;
      acc    = 1'b0;
      while (!acc && tries < 4) begin
         cycle(1'b1, ins, alu, acc);
         if (!obs_ready) stalls++;
         tries++;
      end
   endtask

   initial begin
      int st, pulses, st_total;
      logic acc;
      logic [31:0] ins;
      logic [6:0] op;
      reset_model();
      bus.instr_valid   = 1'b1;
      bus.instruction_R = enc(OP_R, 5'd3, 5'd1, 5'd2);
      bus.ALUResult_R   = 32'hA5A5_A5A5;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_ready", {31'b0, bus.instr_ready}, 32'd0);
      chk("rst_op_valid", {31'b0, bus.op_valid}, 32'd0);
      chk("rst_rd1", bus.Read_data1_R, 32'd0);
      chk("rst_rd2", bus.Read_data2_R, 32'd0);
      chk("rst_wb_en", {31'b0, bus.wb_en}, 32'd0);
      chk("rst_wb_addr", {27'b0, bus.wb_addr}, 32'd0);
      chk("rst_wb_data", bus.wb_data, 32'd0);
      chk("rst_illegal", {31'b0, bus.illegal}, 32'd0);
      rst = 1'b0;
      bus.instr_valid = 1'b0;
      #1;
      chk("ready_after_rst", {31'b0, bus.instr_ready}, 32'd1);

      // Preload x1=5, x2=8, then add x4,x1,x2 with ALU result 13
      issue(enc(OP_R, 5'd1, 5'd0, 5'd0), 32'd0, st);
      issue(enc(OP_R, 5'd2, 5'd0, 5'd0), 32'd5, st);
      issue(enc(OP_R, 5'd4, 5'd1, 5'd2), 32'd8, st);
      #2;
      chk("add_rd1", bus.Read_data1_R, 32'd5);
      chk("add_rd2", bus.Read_data2_R, 32'd8);
      chk("add_op_valid", {31'b0, bus.op_valid}, 32'd1);

      // sub x6,x4,x3 right behind the add: forwarded or one-cycle stall
      issue({7'b0100000, 5'd3, 5'd4, 3'b0, 5'd6, OP_R}, 32'd13, st);
      chk("raw_stall_cycles", st, EXP_STALL);
      #2;
      chk("sub_rd1", bus.Read_data1_R, 32'd13);

      // rd=0 with all-ones result, then read x0 back
      issue(enc(OP_R, 5'd0, 5'd1, 5'd2), 32'd13, st);
      #2;
      chk("x0_wb_en", {31'b0, bus.wb_en}, 32'd0);
      issue(enc(OP_R, 5'd7, 5'd0, 5'd4), 32'hFFFF_FFFF, st);
      #2;
      chk("x0_reads_zero", bus.Read_data1_R, 32'd0);
      chk("x4_still_13", bus.Read_data2_R, 32'd13);

      // Illegal opcode
      issue(enc(OP_I, 5'd9, 5'd1, 5'd2), 32'd77, st);
      #2;
      chk("illegal_pulse", {31'b0, bus.illegal}, 32'd1);
      chk("illegal_no_op", {31'b0, bus.op_valid}, 32'd0);
      issue(enc(OP_R, 5'd10, 5'd9, 5'd1), 32'd0, st);
      #2;
      chk("illegal_drops", {31'b0, bus.illegal}, 32'd0);
      chk("x9_untouched", bus.Read_data1_R, 32'd0);
      chk("x1_still_5", bus.Read_data2_R, 32'd5);

      // Reset while op_valid=1 (x10 pending)
      @(negedge clk);
      bus.instr_valid = 1'b0;
      bus.ALUResult_R = 32'hDEAD_BEEF;
      rst = 1'b1;
      #1;
      chk("mid_rst_op_valid", {31'b0, bus.op_valid}, 32'd0);
      chk("mid_rst_rd1", bus.Read_data1_R, 32'd0);
      chk("mid_rst_rd2", bus.Read_data2_R, 32'd0);
      chk("mid_rst_wb_en", {31'b0, bus.wb_en}, 32'd0);
      chk("mid_rst_wb_data", bus.wb_data, 32'd0);
      chk("mid_rst_ready", {31'b0, bus.instr_ready}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      reset_model();
      #1;
      chk("mid_rst_ready_after", {31'b0, bus.instr_ready}, 32'd1);
      issue(enc(OP_R, 5'd11, 5'd10, 5'd1), 32'd0, st);
      #2;
      chk("x10_not_written", bus.Read_data1_R, 32'd0);
      cycle(1'b0, 32'd0, 32'd0, acc);

      // 20 independent instructions back to back
      pulses   = 0;
      st_total = 0;
      for (int i = 0; i < 20; i++) begin
         ins = enc(OP_R, 5'(12 + i), 5'($urandom_range(1, 11)), 5'($urandom_range(1, 11)));
         issue(ins, $urandom, st);
         st_total += st;
         #2;
         if (bus.op_valid === 1'b1) pulses++;
      end
      chk("b2b_stalls", st_total, 32'd0);
      chk("b2b_pulses", pulses, 32'd20);

      // Random traffic with frequent hazards
      for (int i = 0; i < 300; i++) begin
         op  = ($urandom_range(0, 15) == 0) ? OP_I : OP_R;
         ins = enc(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         ins = ins | ($urandom & 32'hFE00_7000);
         cycle($urandom_range(0, 3) != 0, ins, $urandom, acc);
      end
      repeat (2) cycle(1'b0, 32'd0, $urandom, acc);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/rtype_regfile_wb.md
RTYPE_REGFILE_WB -- requirements
Module: rtype_regfile_wb

Interface
REQ-001 Parameter N, default 32: data width of the register file, operands and result.
REQ-002 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1: asynchronous, active-high reset.
REQ-004 Port instr_valid, input, 1: an instruction is presented on instruction_R.
REQ-005 Port instr_ready, output, 1: the block accepts the instruction this cycle.
REQ-006 Port instruction_R, input, 32: instruction word with fields rs2[24:20], rs1[19:15], rd[11:7] and opcode[6:0].
REQ-007 Port Read_data1_R, output, N: registered rs1 operand sent to the ALU.
REQ-008 Port Read_data2_R, output, N: registered rs2 operand sent to the ALU.
REQ-009 Port op_valid, output, 1: the operands and the issued instruction are valid this cycle.
REQ-010 Port ALUResult_R, input, N: combinational ALU result; sampled only while op_valid=1.
REQ-011 Port wb_en, output, 1: a register write occurs at the end of this cycle.
REQ-012 Port wb_addr, output, 5: destination register of the write.
REQ-013 Port wb_data, output, N: data being written.
REQ-014 Port illegal, output, 1: one-cycle pulse when an accepted instruction has an opcode other than 0110011.

Function
REQ-015 Storage: 32 registers x N bits; x0 reads as 0 and ignores all writes.
REQ-016 Acceptance: an instruction is accepted on a rising edge where instr_valid=1 and instr_ready=1.
REQ-017 Issue, cycle N+1: an instruction accepted at edge N with opcode 0110011 drives op_valid=1 for exactly one cycle and presents its rs1/rs2 register values on Read_data1_R/Read_data2_R.
REQ-018 Illegal opcode: the block still accepts the instruction; it pulses illegal in cycle N+1, leaves op_valid=0 and performs no write.
REQ-019 Writeback: while op_valid=1, wb_en=1, wb_addr=rd of the issued instruction and wb_data=ALUResult_R; the register is written at the closing edge, so the ALU-to-register latency is 1 cycle after issue.
REQ-020 x0 destination: when rd=0, wb_en=0 and no write occurs.
REQ-021 Hazard definition: an incoming instruction whose rs1 or rs2 equals the pending rd (op_valid=1, rd≠0) is a hazard.
REQ-022 Throughput: without a hazard, instr_ready=1 every cycle after reset, giving one instruction per cycle back to back.
REQ-023 Read_data1_R, Read_data2_R and op_valid hold their previous data and drop op_valid when no instruction is accepted.
REQ-024 Width: operand and result paths are exactly N bits; no sign extension and no truncation.

Reset
REQ-025 While rst=1, regardless of clk, all 32 registers, Read_data1_R, Read_data2_R, op_valid, wb_en, wb_addr, wb_data and illegal clear to 0.
REQ-026 Reset asserted mid-operation discards the in-flight instruction; no write occurs for it.
REQ-027 instr_ready is 0 while rst=1 and is 1 in the first cycle after release.

Configuration
REQ-028 Macro WB_BYPASS_EN defined: on a hazard, instr_ready stays 1 and the matching operand is taken from ALUResult_R instead of the register array, so there is no stall.
REQ-029 Macro WB_BYPASS_EN undefined: on a hazard, instr_ready=0 for that cycle (a one-cycle stall) and the instruction is accepted on the next edge with the register value already written.

Verification
REQ-030 Scenario: after reset, x1=5 and x2=8 are preloaded via prior writebacks; add x4,x1,x2 -> next cycle Read_data1_R=5, Read_data2_R=8, op_valid=1; with ALU returning 13, x4=13.
REQ-031 Scenario: back-to-back add x4 then sub x6,x4,x3 -> with WB_BYPASS_EN, Read_data1_R equals the ALUResult_R of the add and there is no stall; without the macro, instr_ready=0 for exactly one cycle and Read_data1_R=13.
REQ-032 Scenario: instruction with rd=0 and ALU result 0xFFFFFFFF -> wb_en=0 and x0 still reads 0.
REQ-033 Scenario: opcode 0010011 presented -> illegal pulses once, op_valid=0, no register changes.
REQ-034 Scenario: rst asserted while op_valid=1 -> all outputs are 0 immediately, the destination register is unchanged, and instr_ready=1 after release.
REQ-035 Scenario: 20 consecutive independent instructions -> 20 op_valid pulses in 20 consecutive cycles with correct writebacks.
